nand_tree_pipe: RTL and testbench



---
 rtl/nand_tree_pipe.sv | 146 ++++++++++++++
 tb/tb_nand_tree_pipe.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_tree_pipe.sv
// Pipelined N-input NAND/AND/NOR/OR reduction tree with per-level valid/ready handshake.
// Define NAND_TREE_TOGGLE_CNT_EN to add the TOG_CLR/TOG_CNT output toggle counter.
module nand_tree_pipe #(
  parameter int N     = 16,
  parameter int FANIN = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] IN,
  input  logic [1:0]   MODE,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic         QN,
  output logic         QN_VALID,
  input  logic         QN_READY
`ifdef NAND_TREE_TOGGLE_CNT_EN
  ,
  input  logic         TOG_CLR,
  output logic [15:0]  TOG_CNT
`endif
);

  function automatic int lvl_w(input int k);
    int w;
    w = N;
    for (int i = 0; i < k; i++) w = (w + FANIN - 1) / FANIN;
    return w;
  endfunction

  function automatic int calc_s();
    int w;
    int s;
    w = N;
    s = 0;
    while (w > 1) begin
      w = (w + FANIN - 1) / FANIN;
      s++;
    end
    if (s < 1) s = 1;
    return s;
  endfunction

  localparam int S = calc_s();

  // Groups of FANIN bits reduce to one; slots past the live width hold the identity value.
  function automatic logic [N-1:0] reduce_lvl(input logic [N-1:0] x, input int win,
                                              input logic use_or);
    logic [N-1:0] r;
    logic         acc;
    int           idx;
    r = '0;
    for (int g = 0; g < N; g++) begin
      acc = ~use_or;
      for (int j = 0; j < FANIN; j++) begin
        idx = g * FANIN + j;
        if (idx < win) acc = use_or ? (acc | x[idx]) : (acc & x[idx]);
      end
      r[g] = acc;
    end
    return r;
  endfunction

  // NAND (0) and NOR (2) invert the final level.
  function automatic logic finish_bit(input logic b, input logic [1:0] m);
    return b ^ ~m[0];
  endfunction

  logic [N-1:0] dat_q [1:S];
  logic [1:0]   mod_q [1:S];
  logic [S:1]   vld_q;

  logic [N-1:0] src_d [0:S-1];
  logic [1:0]   src_m [0:S-1];
  logic         src_v [0:S-1];
  logic [N-1:0] dat_d [1:S];
  logic [S:1]   rdy;

  always_comb begin
    src_d[0] = IN;
    src_m[0] = MODE;
    src_v[0] = IN_VALID;
    for (int k = 1; k < S; k++) begin
      src_d[k] = dat_q[k];
      src_m[k] = mod_q[k];
      src_v[k] = vld_q[k];
    end
  end

  always_comb begin
    for (int k = 1; k <= S; k++) begin
      dat_d[k] = reduce_lvl(src_d[k-1], lvl_w(k - 1), src_m[k-1][1]);
    end
    dat_d[S][0] = finish_bit(dat_d[S][0], src_m[S-1]);
  end

  // A stage can load if it or any stage downstream holds a bubble, or the consumer takes QN.
  always_comb begin
    logic r;
    r = 1'b0;
    for (int k = 1; k <= S; k++) begin
      r = QN_READY;
      for (int j = k; j <= S; j++) r = r | ~vld_q[j];
      rdy[k] = r;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q    <= '0;
      dat_q[S] <= '0;
    end else begin
      for (int k = 1; k <= S; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= src_v[k-1];
          mod_q[k] <= src_m[k-1];
          dat_q[k] <= dat_d[k];
        end
      end
    end
  end

  assign IN_READY = rdy[1];
  assign QN       = dat_q[S][0];
  assign QN_VALID = vld_q[S];

  logic unused_stage_bits;
  assign unused_stage_bits = ^{dat_q[S], mod_q[S]};

`ifdef NAND_TREE_TOGGLE_CNT_EN
  logic [15:0] tog_q;
  logic        ref_q;

  always_ff @(posedge CLK) begin
    if (RST || TOG_CLR) begin
      tog_q <= '0;
      ref_q <= 1'b0;
    end else if (QN_VALID && QN_READY) begin
      ref_q <= QN;
      if ((QN != ref_q) && (tog_q != 16'hFFFF)) tog_q <= tog_q + 16'd1;
    end
  end

  assign TOG_CNT = tog_q;
`endif

endmodule

// File: tb/tb_nand_tree_pipe.sv
// Randomized and directed bench for nand_tree_pipe against a flat N-input reduction model.
// Two instances: N=16/FANIN=4 (depth 2) and N=5/FANIN=2 (depth 3).
module tb_nand_tree_pipe;
  localparam int NA = 16, FA = 4, SA = 2;
  localparam int NB = 5,  FB = 2, SB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NA-1:0] in_a = '0;
  logic [1:0]    mode_a = '0;
  logic          iv_a = 1'b0, qr_a = 1'b1;
  logic          ir_a, qn_a, qv_a;
  logic [NB-1:0] in_b = '0;
  logic [1:0]    mode_b = '0;
  logic          iv_b = 1'b0, qr_b = 1'b1;
  logic          ir_b, qn_b, qv_b;
`ifdef NAND_TREE_TOGGLE_CNT_EN
  logic          tclr_a = 1'b0, tclr_b = 1'b0;
  logic [15:0]   tcnt_a, tcnt_b;
`endif

  int checks = 0;
  int errors = 0;

  nand_tree_pipe #(.N(NA), .FANIN(FA)) dut_a (
    .CLK(clk), .RST(rst), .IN(in_a), .MODE(mode_a), .IN_VALID(iv_a), .IN_READY(ir_a),
    .QN(qn_a), .QN_VALID(qv_a), .QN_READY(qr_a)
`ifdef NAND_TREE_TOGGLE_CNT_EN
    , .TOG_CLR(tclr_a), .TOG_CNT(tcnt_a)
`endif
  );

  nand_tree_pipe #(.N(NB), .FANIN(FB)) dut_b (
    .CLK(clk), .RST(rst), .IN(in_b), .MODE(mode_b), .IN_VALID(iv_b), .IN_READY(ir_b),
    .QN(qn_b), .QN_VALID(qv_b), .QN_READY(qr_b)
`ifdef NAND_TREE_TOGGLE_CNT_EN
    , .TOG_CLR(tclr_b), .TOG_CNT(tcnt_b)
`endif
  );

  // Flat reference: the plain N-input gate selected by mode.
  function automatic logic ref_fn(input logic [63:0] v, input int n, input logic [1:0] m);
    logic all1, any1;
    all1 = 1'b1;
    any1 = 1'b0;
    for (int i = 0; i < n; i++) begin
      all1 = all1 & v[i];
      any1 = any1 | v[i];
    end
    case (m)
      2'd0:    return ~all1;
      2'd1:    return all1;
      2'd2:    return ~any1;
      default: return any1;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    iv_a = 1'b1; in_a = 16'hFFFF; mode_a = 2'd1;
    iv_b = 1'b1; in_b = 5'h1F;    mode_b = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (qv_a !== 1'b0 || qn_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a qv=%b qn=%b expected 0 0", qv_a, qn_a);
    end
    checks++;
    if (qv_b !== 1'b0 || qn_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b qv=%b qn=%b expected 0 0", qv_b, qn_b);
    end
`ifdef NAND_TREE_TOGGLE_CNT_EN
    checks++;
    if (tcnt_a !== 16'h0) begin
      errors++;
      $display("FAIL reset_tog cnt=%h expected 0000", tcnt_a);
    end
`endif
    rst = 1'b0;
    iv_a = 1'b0;
    iv_b = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ir_a !== 1'b1 || ir_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready ir_a=%b ir_b=%b expected 1 1", ir_a, ir_b);
    end
  endtask

  // One operand presented in the cycle after edge t; result expected exactly after edge t+S.
  task automatic run_one(input bit sel_b, input logic [15:0] v, input logic [1:0] m,
                         input string name);
    int    s, edges;
    logic  exp, rdy, qv, qn;
    s   = sel_b ? SB : SA;
    exp = sel_b ? ref_fn({59'd0, v[4:0]}, NB, m) : ref_fn({48'd0, v}, NA, m);
    @(posedge clk);
    #1;
    qr_a = 1'b1; qr_b = 1'b1;
    if (sel_b) begin in_b = v[4:0]; mode_b = m; iv_b = 1'b1; end
    else begin in_a = v; mode_a = m; iv_a = 1'b1; end
    #1;
    rdy = sel_b ? ir_b : ir_a;
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready ir=%b expected 1", name, rdy);
    end
    @(posedge clk);
    #1;
    iv_a = 1'b0; iv_b = 1'b0;
    edges = 1;
    while (edges < s) begin
      qv = sel_b ? qv_b : qv_a;
      checks++;
      if (qv !== 1'b0) begin
        errors++;
        $display("FAIL %s_early qv=%b expected 0 at edge %0d", name, qv, edges);
      end
      @(posedge clk);
      #1;
      edges++;
    end
    qv = sel_b ? qv_b : qv_a;
    qn = sel_b ? qn_b : qn_a;
    checks++;
    if (qv !== 1'b1 || qn !== exp) begin
      errors++;
      $display("FAIL %s qv=%b qn=%b expected qv=1 qn=%b", name, qv, qn, exp);
    end
  endtask

  task automatic test_functional();
    run_one(1'b0, 16'hFFFF, 2'd0, "nand_ones");
    run_one(1'b0, 16'hFFFE, 2'd0, "nand_one_zero");
    run_one(1'b0, 16'h0000, 2'd2, "nor_zeros");
    run_one(1'b0, 16'h0100, 2'd3, "or_single");
    run_one(1'b0, 16'hFFFF, 2'd1, "and_ones");
    run_one(1'b0, 16'h8000, 2'd2, "nor_msb");
    for (int i = 0; i < 4; i++) run_one(1'b0, 16'($urandom), 2'(i), "rand_mode");
  endtask

  task automatic test_padding();
    run_one(1'b1, 16'h001F, 2'd1, "pad_and_ones");
    run_one(1'b1, 16'h000F, 2'd1, "pad_and_msb0");
    run_one(1'b1, 16'h001F, 2'd0, "pad_nand_ones");
    run_one(1'b1, 16'h0000, 2'd2, "pad_nor_zeros");
    run_one(1'b1, 16'h0010, 2'd3, "pad_or_msb");
  endtask

  // kind 0: random valid/ready; kind 1: 8 operands, consumer stalls cycles 3..7.
  task automatic stream_a(input int kind, input int n_ops, input int max_cyc, input string name);
    logic exp_q[$];
    logic e, exp_ir, prev_stall, prev_qn;
    int   sent, got;
    bit   saw_block;
    sent = 0; got = 0; saw_block = 1'b0;
    prev_stall = 1'b0; prev_qn = 1'b0;
    for (int cyc = 0; cyc < max_cyc && got < n_ops; cyc++) begin
      @(posedge clk);
      #1;
      if (prev_stall) begin
        checks++;
        if (qv_a !== 1'b1 || qn_a !== prev_qn) begin
          errors++;
          $display("FAIL %s_hold qv=%b qn=%b expected 1 %b", name, qv_a, qn_a, prev_qn);
        end
      end
      if (exp_q.size() == 0) begin
        checks++;
        if (qv_a !== 1'b0) begin
          errors++;
          $display("FAIL %s_spurious qv=%b expected 0", name, qv_a);
        end
      end
      iv_a   = (sent < n_ops) && (kind == 1 || $urandom_range(0, 3) != 0);
      in_a   = 16'($urandom);
      mode_a = 2'($urandom_range(0, 3));
      qr_a   = (kind == 1) ? !(cyc >= 3 && cyc <= 7) : ($urandom_range(0, 3) != 0);
      #1;
      exp_ir = !(exp_q.size() == SA && !qr_a);
      checks++;
      if (ir_a !== exp_ir) begin
        errors++;
        $display("FAIL %s_inready ir=%b expected %b occ=%0d", name, ir_a, exp_ir, exp_q.size());
      end
      if (!ir_a) saw_block = 1'b1;
      if (qv_a && qr_a && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (qn_a !== e) begin
          errors++;
          $display("FAIL %s_data result %0d qn=%b expected %b", name, got, qn_a, e);
        end
        got++;
      end
      if (iv_a && ir_a) begin
        exp_q.push_back(ref_fn({48'd0, in_a}, NA, mode_a));
        sent++;
      end
      prev_stall = qv_a && !qr_a;
      prev_qn    = qn_a;
    end
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    qr_a = 1'b1;
    checks++;
    if (got != n_ops || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_count delivered=%0d pending=%0d expected %0d 0", name, got,
               exp_q.size(), n_ops);
    end
    if (kind == 1) begin
      checks++;
      if (!saw_block) begin
        errors++;
        $display("FAIL %s_block ir never low expected low while full", name);
      end
    end
  endtask

  task automatic test_back_pressure();
    stream_a(1, 8, 60, "backpressure");
  endtask

  task automatic test_random_stream();
    stream_a(0, 300, 3000, "random");
  endtask

  task automatic test_reset_midstream();
    @(posedge clk);
    #1;
    qr_a = 1'b0; iv_a = 1'b1; in_a = 16'($urandom); mode_a = 2'd3;
    @(posedge clk);
    #1;
    in_a = 16'hFFFF; mode_a = 2'd1;
    @(posedge clk);
    #1;
    checks++;
    if (qv_a !== 1'b1) begin
      errors++;
      $display("FAIL midrst_inflight qv=%b expected 1", qv_a);
    end
    rst = 1'b1;
    iv_a = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (qv_a !== 1'b0 || qn_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear qv=%b qn=%b expected 0 0", qv_a, qn_a);
    end
    rst = 1'b0;
    qr_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (qv_a !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale cycle %0d qv=%b expected 0", i, qv_a);
      end
    end
    checks++;
    if (ir_a !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready ir=%b expected 1", ir_a);
    end
    run_one(1'b0, 16'h0001, 2'd3, "after_midrst");
  endtask

`ifdef NAND_TREE_TOGGLE_CNT_EN
  task automatic test_toggle();
    logic        seq [5];
    logic        prev;
    int          model;
    seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    @(posedge clk);
    #1;
    tclr_a = 1'b1;
    @(posedge clk);
    #1;
    tclr_a = 1'b0;
    checks++;
    if (tcnt_a !== 16'h0) begin
      errors++;
      $display("FAIL tog_clear0 cnt=%h expected 0000", tcnt_a);
    end
    prev = 1'b0; model = 0;
    qr_a = 1'b1; mode_a = 2'd1;
    for (int i = 0; i < 5; i++) begin
      iv_a = 1'b1;
      in_a = seq[i] ? 16'hFFFF : 16'h0000;
      if (seq[i] != prev) model++;
      prev = seq[i];
      @(posedge clk);
      #1;
    end
    iv_a = 1'b0;
    repeat (SA + 2) @(posedge clk);
    #1;
    checks++;
    if (tcnt_a !== 16'(model)) begin
      errors++;
      $display("FAIL tog_count cnt=%0d expected %0d", tcnt_a, model);
    end
    tclr_a = 1'b1;
    @(posedge clk);
    #1;
    tclr_a = 1'b0;
    checks++;
    if (tcnt_a !== 16'h0) begin
      errors++;
      $display("FAIL tog_clear cnt=%h expected 0000", tcnt_a);
    end
    prev = 1'b0; model = 0;
    for (int i = 0; i < 70000; i++) begin
      iv_a = 1'b1;
      in_a = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      if ((i % 2 == 0) != prev) model++;
      prev = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    iv_a = 1'b0;
    repeat (SA + 2) @(posedge clk);
    #1;
    if (model > 65535) model = 65535;
    checks++;
    if (tcnt_a !== 16'(model)) begin
      errors++;
      $display("FAIL tog_saturate cnt=%h expected %h", tcnt_a, 16'(model));
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_functional();
    test_padding();
    test_back_pressure();
    test_random_stream();
    test_reset_midstream();
`ifdef NAND_TREE_TOGGLE_CNT_EN
    test_toggle();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
